// File: rtl/meta_info_broadcast_n.sv
// Fans one upstream meta-info descriptor out to NrConsumers stages, each with its own
// Depth-entry FIFO, so every consumer drains at its own pace.
module meta_info_broadcast_n #(
    parameter int unsigned NrConsumers = 2,
    parameter int unsigned Depth       = 2,
    parameter type         meta_glb_t  = logic,
    localparam int unsigned CntWidth   = $clog2(Depth + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   flush_i,
    input  logic                                   meta_info_valid_i,
    output logic                                   meta_info_ready_o,
    input  meta_glb_t                              meta_info_i,
    input  logic      [NrConsumers-1:0]            meta_cons_mask_i,
    output logic      [NrConsumers-1:0]            cons_valid_o,
    input  logic      [NrConsumers-1:0]            cons_ready_i,
    output meta_glb_t [NrConsumers-1:0]            cons_o,
    output logic      [NrConsumers-1:0][CntWidth-1:0] cons_cnt_o,
    output logic                                   idle_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    typedef logic [PtrWidth-1:0] ptr_t;
    typedef logic [CntWidth-1:0] cnt_t;

    localparam cnt_t CntFull = cnt_t'(Depth);
    localparam ptr_t PtrLast = ptr_t'(Depth - 1);

    ptr_t      wr_ptr_q [NrConsumers];
    ptr_t      rd_ptr_q [NrConsumers];
    cnt_t      cnt_q    [NrConsumers];
    meta_glb_t mem_q    [NrConsumers][Depth];

    logic                   accept;
    logic [NrConsumers-1:0] push_en;
    logic [NrConsumers-1:0] pop_en;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PtrLast) ? '0 : p + ptr_t'(1);
    endfunction

    // Handshake: a transfer happens on an edge where valid and ready are both high.
    // Upstream ready looks only at flush, the mask and registered counts, never at
    // meta_info_valid_i or cons_ready_i; consumer valid is raised from the count alone
    // and holds with stable data until the consumer takes it.
    always_comb begin
        meta_info_ready_o = !flush_i;
        for (int k = 0; k < NrConsumers; k++) begin
            if (meta_cons_mask_i[k] && (cnt_q[k] == CntFull)) begin
                meta_info_ready_o = 1'b0;
            end
        end
    end

    assign accept = meta_info_valid_i & meta_info_ready_o;

    always_comb begin
        push_en = '0;
        pop_en  = '0;
        idle_o  = 1'b1;
        for (int k = 0; k < NrConsumers; k++) begin
            push_en[k]      = accept & meta_cons_mask_i[k];
            cons_valid_o[k] = (cnt_q[k] != '0);
            pop_en[k]       = cons_valid_o[k] & cons_ready_i[k] & !flush_i;
            cons_o[k]       = mem_q[k][rd_ptr_q[k]];
            cons_cnt_o[k]   = cnt_q[k];
            if (cnt_q[k] != '0) begin
                idle_o = 1'b0;
            end
        end
    end

    // Flush wins over any push or pop offered in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NrConsumers; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < NrConsumers; k++) begin
                if (flush_i) begin
                    wr_ptr_q[k] <= '0;
                    rd_ptr_q[k] <= '0;
                    cnt_q[k]    <= '0;
                end else begin
                    if (push_en[k]) begin
                        wr_ptr_q[k] <= ptr_inc(wr_ptr_q[k]);
                    end
                    if (pop_en[k]) begin
                        rd_ptr_q[k] <= ptr_inc(rd_ptr_q[k]);
                    end
                    case ({push_en[k], pop_en[k]})
                        2'b10:   cnt_q[k] <= cnt_q[k] + cnt_t'(1);
                        2'b01:   cnt_q[k] <= cnt_q[k] - cnt_t'(1);
                        default: cnt_q[k] <= cnt_q[k];
                    endcase
                end
            end
        end
    end

    // Storage needs no reset: entries are only visible once a count covers them.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NrConsumers; k++) begin
            if (push_en[k]) begin
                mem_q[k][wr_ptr_q[k]] <= meta_info_i;
            end
        end
    end

    a_desc_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (meta_info_valid_i && !meta_info_ready_o && !flush_i)
            |=> (!meta_info_valid_i || $stable(meta_info_i)));

    for (genvar k = 0; k < NrConsumers; k++) begin : g_chk
        a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
            push_en[k] |-> (cnt_q[k] != CntFull));
        a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
            pop_en[k] |-> (cnt_q[k] != '0));
        a_cnt_range: assert property (@(posedge clk_i) disable iff (rst_i)
            cnt_q[k] <= CntFull);
    end

endmodule
